puf_dp_ctrl: RTL and testbench
==============================

Name: puf_dp_ctrl

Overview:
- Sequencer for the PUF datapath (LFSR scrambler, then ECC decoder, then output mux).
- On a start request it latches the seed and mode, then resets and enables the scrambler.
- In corrected mode it also resets and enables the ECC decoder; it then steers mux1_sel and captures the 256-bit result.
- Provides a start/busy/done/ack handshake and a watchdog timeout to the host/security-engine top level.

Parameters:
- DATA_W, 256, width of datapath result captured.
- SEED_W, 8, scrambler seed width.
- TIMEOUT, 1023, max cycles allowed in any RUN state before error (must be >= 1).
- CNT_W, 10, watchdog counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  host request; sampled only in IDLE.
- mode  input  1  0 = raw scrambled output, 1 = ECC-corrected output; latched with start.
- seed_in  input  SEED_W  scrambler seed; latched with start.
- ack  input  1  host acknowledges result/error; returns FSM to IDLE.
- done_scr  input  1  from datapath done_Scrambler.
- done_ecc  input  1  from datapath done_ECC_Dec.
- dp_data  input  DATA_W  datapath data_out.
- en_scr  output  1  to En_Scrambler.
- rst_scr  output  1  to Reset_Scrambler, active-high pulse.
- seed_scr  output  SEED_W  to Seed_Scrambler (registered).
- en_ecc  output  1  to En_ECC_Dec.
- rst_ecc  output  1  to Reset_ECC_Dec, active-high pulse.
- mux_sel  output  1  to mux1_sel; 1 selects ECC output.
- busy  output  1  high from accepted start until DONE/ERR.
- done  output  1  result valid; held until ack.
- err  output  1  watchdog expired; held until ack.
- result  output  DATA_W  captured datapath output; stable while done=1.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - All outputs 0, including seed_scr and result.
  - Watchdog counter 0.
- States: IDLE, SCR_RST, SCR_RUN, ECC_RST, ECC_RUN, CAPTURE, DONE, ERR. All outputs are registered (Moore).
- IDLE:
  - start=1 latches mode and seed_in (seed_scr updates the next cycle) and sets busy.
  - Goes to SCR_RST.
  - start while not IDLE is ignored; there is no queueing.
- SCR_RST: rst_scr=1 for exactly 1 cycle, en_scr=0, then SCR_RUN.
- SCR_RUN:
  - en_scr=1; the watchdog increments each cycle.
  - On done_scr=1:
    - mode=0: mux_sel=0, go to CAPTURE.
    - mode=1: go to ECC_RST.
  - Watchdog reaching TIMEOUT without done goes to ERR.
  - done_scr sampled in the same cycle as timeout wins (success).
- ECC_RST:
  - rst_ecc=1 for 1 cycle; en_scr drops to 0.
  - Scrambler output holds; seed_scr unchanged.
  - Watchdog clears; then ECC_RUN.
- ECC_RUN:
  - en_ecc=1; the watchdog increments each cycle.
  - On done_ecc=1: mux_sel=1, go to CAPTURE.
  - Timeout goes to ERR, with the same done-wins tie rule.
- CAPTURE:
  - One cycle with en_* deasserted; the mux settles with mux_sel held.
  - result <= dp_data at the end of this cycle.
- DONE:
  - done=1 and busy=0; result and mux_sel held.
  - ack=1 clears done, goes to IDLE.
  - ack and start together in DONE: ack is honoured; start is ignored that cycle.
- ERR:
  - err=1 and busy=0; en_* are 0 and result is unchanged from the prior capture.
  - ack=1 goes to IDLE.
- Latency:
  - mode=0: done at N_scr+4 cycles after start.
  - mode=1: N_scr+N_ecc+6 cycles after start.
  - N_* is the number of cycles each enable is held before its done.
- Watchdog:
  - Clears on every RST state entry.
  - Saturates at TIMEOUT; never wraps.
- done_scr/done_ecc pulses outside their RUN states are ignored.
- Reset mid-operation: immediate return to IDLE, all enables low; a new start re-seeds and re-resets the datapath.

Decomposition:
- Shared package puf_ctrl_pkg holds:
  - State encoding constants (3-bit, IDLE=0).
  - Mode constants MODE_RAW=0, MODE_ECC=1.
  - MUX_SCR=0, MUX_ECC=1.
- Sub-module puf_watchdog: loadable saturating counter with clear, inc, and expired output.
- FSM and result register stay in the top module.

Test Plan:
- Raw mode: start, mode=0, seed=8'hA5; done_scr after 4 cycles -> seed_scr=A5, rst_scr 1-cycle pulse, en_ecc never high, mux_sel=0, result=dp_data at CAPTURE, done at cycle 8.
- ECC mode: mode=1, done_scr after 4 cycles, done_ecc after 10 cycles -> rst_ecc single pulse after en_scr drops, mux_sel=1, done at cycle 20, result captured.
- Timeout: TIMEOUT=15, done_scr never asserted -> err=1 after 15 SCR_RUN cycles, en_scr=0, busy=0; ack -> IDLE; a new start succeeds.
- Tie and ignored inputs:
  - done_ecc in the same cycle the watchdog hits TIMEOUT -> success path.
  - start pulsed during SCR_RUN -> no effect on latched seed/mode.
  - spurious done_ecc in SCR_RUN -> ignored.
- Handshake: done held 50 cycles with result stable; ack+start together -> IDLE, no new run; start the next cycle -> run begins.
- Async reset asserted mid-ECC_RUN -> all outputs 0 immediately (before next clk edge); after release, idle until start.

Source files
------------

// File: rtl/puf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// puf_ctrl_pkg : shared state encoding and select constants for the PUF sequencer
// Rev 1.0
// ============================================================================
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SCR_RST = 3'd1,
        S_SCR_RUN = 3'd2,
        S_ECC_RST = 3'd3,
        S_ECC_RUN = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_t;

    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_ECC = 1'b1;
    localparam logic MUX_SCR  = 1'b0;
    localparam logic MUX_ECC  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/puf_watchdog.sv
`default_nettype none
// ============================================================================
// puf_watchdog : saturating cycle counter with clear; flags the cycle it hits TIMEOUT
// Rev 1.0
// ============================================================================
module puf_watchdog #(
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [CNT_W-1:0] c_limit = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_last  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_limit)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High during the cycle whose increment brings the count to TIMEOUT
    assign expired = inc && (r_count >= c_last);

endmodule
`default_nettype wire

// File: rtl/puf_dp_ctrl.sv
`default_nettype none
// ============================================================================
// puf_dp_ctrl : sequences scrambler -> ECC decoder -> output mux, with handshake and watchdog
// Rev 1.0
// ============================================================================
module puf_dp_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int DATA_W  = 256,
    parameter int SEED_W  = 8,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [SEED_W-1:0] seed_in,
    input  logic              ack,
    input  logic              done_scr,
    input  logic              done_ecc,
    input  logic [DATA_W-1:0] dp_data,
    output logic              en_scr,
    output logic              rst_scr,
    output logic [SEED_W-1:0] seed_scr,
    output logic              en_ecc,
    output logic              rst_ecc,
    output logic              mux_sel,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    state_t r_state;
    state_t w_next_state;
    logic   r_mode;
    logic   w_wd_clr;
    logic   w_wd_inc;
    logic   w_wd_expired;

    assign w_wd_inc = (r_state == S_SCR_RUN) || (r_state == S_ECC_RUN);
    assign w_wd_clr = (r_state == S_IDLE) || (r_state == S_SCR_RST) || (r_state == S_ECC_RST);

    puf_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_wd_clr),
        .inc     (w_wd_inc),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A done arriving in the same cycle as the timeout takes priority
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next_state = S_SCR_RST;
            S_SCR_RST: w_next_state = S_SCR_RUN;
            S_SCR_RUN: begin
                if (done_scr) begin
                    w_next_state = (r_mode == MODE_ECC) ? S_ECC_RST : S_CAPTURE;
                end else if (w_wd_expired) begin
                    w_next_state = S_ERR;
                end
            end
            S_ECC_RST: w_next_state = S_ECC_RUN;
            S_ECC_RUN: begin
                if (done_ecc) begin
                    w_next_state = S_CAPTURE;
                end else if (w_wd_expired) begin
                    w_next_state = S_ERR;
                end
            end
            S_CAPTURE: w_next_state = S_DONE;
            S_DONE:    if (ack) w_next_state = S_IDLE;
            S_ERR:     if (ack) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_scr   <= 1'b0;
            rst_scr  <= 1'b0;
            seed_scr <= '0;
            en_ecc   <= 1'b0;
            rst_ecc  <= 1'b0;
            mux_sel  <= MUX_SCR;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            r_mode   <= MODE_RAW;
        end else begin
            en_scr  <= (w_next_state == S_SCR_RUN);
            rst_scr <= (w_next_state == S_SCR_RST);
            en_ecc  <= (w_next_state == S_ECC_RUN);
            rst_ecc <= (w_next_state == S_ECC_RST);
            busy    <= (w_next_state == S_SCR_RST) || (w_next_state == S_SCR_RUN) ||
                       (w_next_state == S_ECC_RST) || (w_next_state == S_ECC_RUN) ||
                       (w_next_state == S_CAPTURE);
            done    <= (w_next_state == S_DONE);
            err     <= (w_next_state == S_ERR);
            if ((r_state == S_IDLE) && start) begin
                seed_scr <= seed_in;
                r_mode   <= mode;
            end
            if ((w_next_state == S_CAPTURE) && (r_state != S_CAPTURE)) begin
                mux_sel <= (r_state == S_ECC_RUN) ? MUX_ECC : MUX_SCR;
            end
            if (r_state == S_CAPTURE) begin
                result <= dp_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_puf_dp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_puf_dp_ctrl : directed + randomized check of puf_dp_ctrl against a cycle-timing model
// Rev 1.0
// ============================================================================
module tb_puf_dp_ctrl;

    localparam int DATA_W     = 256;
    localparam int SEED_W     = 8;
    localparam int TIMEOUT_TB = 15;
    localparam int CNT_W      = 4;
    localparam int NEVER      = 1000;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              mode;
    logic [SEED_W-1:0] seed_in;
    logic              ack;
    logic              done_scr;
    logic              done_ecc;
    logic [DATA_W-1:0] dp_data;
    logic              en_scr;
    logic              rst_scr;
    logic [SEED_W-1:0] seed_scr;
    logic              en_ecc;
    logic              rst_ecc;
    logic              mux_sel;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    int          checks;
    int          errors;
    int          cur_k;
    logic        prev_mux;
    logic [255:0] prev_result;

    puf_dp_ctrl #(
        .DATA_W  (DATA_W),
        .SEED_W  (SEED_W),
        .TIMEOUT (TIMEOUT_TB),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .mode     (mode),
        .seed_in  (seed_in),
        .ack      (ack),
        .done_scr (done_scr),
        .done_ecc (done_ecc),
        .dp_data  (dp_data),
        .en_scr   (en_scr),
        .rst_scr  (rst_scr),
        .seed_scr (seed_scr),
        .en_ecc   (en_ecc),
        .rst_ecc  (rst_ecc),
        .mux_sel  (mux_sel),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cur_k, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_idle(input logic [7:0] sd);
        chk("idle_busy", busy, 1'b0);
        chk("idle_done", done, 1'b0);
        chk("idle_err", err, 1'b0);
        chk("idle_en_scr", en_scr, 1'b0);
        chk("idle_en_ecc", en_ecc, 1'b0);
        chk("idle_rst_scr", rst_scr, 1'b0);
        chk("idle_rst_ecc", rst_ecc, 1'b0);
        chk("idle_seed", seed_scr, sd);
        chk("idle_mux", mux_sel, prev_mux);
        chk("idle_result", result, prev_result);
    endtask

    // One full transaction. Cycle 0 carries start; cycle k is observed #1 after edge k.
    // A datapath stage that needs n enabled cycles raises its done in cycle n+1 of enable.
    task automatic run(input logic m, input logic [7:0] sd, input int nscr, input int necc,
                       input int hold, input logic ack_start);
        int           t;
        int           scr_last;
        int           ecc_first;
        int           ecc_last;
        int           endc;
        bit           scr_ok;
        bit           ecc_ph;
        bit           ok;
        logic [255:0] hist [0:127];
        t         = TIMEOUT_TB;
        scr_ok    = nscr < t;
        scr_last  = scr_ok ? nscr + 2 : t + 1;
        ecc_ph    = m && scr_ok;
        ecc_first = nscr + 4;
        ecc_last  = (necc < t) ? ecc_first + necc : ecc_first + t - 1;
        if (!scr_ok) begin
            ok = 0; endc = t + 2;
        end else if (!m) begin
            ok = 1; endc = nscr + 4;
        end else if (necc < t) begin
            ok = 1; endc = ecc_last + 2;
        end else begin
            ok = 0; endc = ecc_last + 1;
        end

        start = 1'b1; mode = m; seed_in = sd; ack = 1'b0;
        done_scr = 1'b0; done_ecc = 1'b0;
        hist[0] = rnd256(); dp_data = hist[0];

        for (int k = 1; k <= endc + hold; k++) begin
            step();
            cur_k = k;
            chk("rst_scr", rst_scr, k == 1);
            chk("en_scr", en_scr, k >= 2 && k <= scr_last);
            chk("rst_ecc", rst_ecc, ecc_ph && k == scr_last + 1);
            chk("en_ecc", en_ecc, ecc_ph && k >= ecc_first && k <= ecc_last);
            chk("busy", busy, k < endc);
            chk("done", done, ok && k >= endc);
            chk("err", err, !ok && k >= endc);
            chk("seed_scr", seed_scr, sd);
            chk("mux_sel", mux_sel, (ok && k >= endc - 1) ? m : prev_mux);
            chk("result", result, (ok && k >= endc) ? hist[endc-1] : prev_result);

            hist[k]  = rnd256();
            dp_data  = hist[k];
            start    = (k < endc) && ($urandom_range(0, 3) == 0);
            mode     = 1'($urandom);
            seed_in  = 8'($urandom);
            done_scr = (k == nscr + 2) ||
                       ((k < 2 || k > scr_last) && $urandom_range(0, 2) == 0);
            done_ecc = (ecc_ph && necc < t && k == ecc_first + necc) ||
                       (!(ecc_ph && k >= ecc_first && k <= ecc_last) && $urandom_range(0, 2) == 0);
        end

        ack = 1'b1; start = ack_start; done_scr = 1'b0; done_ecc = 1'b0;
        if (ok) begin
            prev_mux    = m;
            prev_result = hist[endc-1];
        end
        step();
        cur_k = endc + hold + 1;
        chk_idle(sd);
        ack = 1'b0; start = 1'b0;
        if (ack_start) begin
            step();
            cur_k++;
            chk("no_run_busy", busy, 1'b0);
            chk("no_run_rst_scr", rst_scr, 1'b0);
        end
    endtask

    initial begin
        checks = 0; errors = 0; cur_k = 0;
        prev_mux = 1'b0; prev_result = '0;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; seed_in = '0; ack = 1'b0;
        done_scr = 1'b0; done_ecc = 1'b0; dp_data = '0;

        step(); step();
        chk_idle(8'h00);
        reset_n = 1'b1;
        step();
        chk_idle(8'h00);

        // Directed scenarios: raw, ECC, timeouts, done-vs-timeout ties, long hold with ack+start
        run(1'b0, 8'hA5, 4, 0, 3, 1'b0);
        run(1'b1, 8'h3C, 4, 10, 2, 1'b0);
        run(1'b0, 8'h11, NEVER, 0, 2, 1'b0);
        run(1'b0, 8'h22, 2, 0, 1, 1'b0);
        run(1'b0, 8'h33, TIMEOUT_TB - 1, 0, 1, 1'b0);
        run(1'b1, 8'h44, 3, TIMEOUT_TB - 1, 1, 1'b0);
        run(1'b1, 8'h55, 1, NEVER, 2, 1'b0);
        run(1'b1, 8'h66, 0, 0, 50, 1'b1);
        run(1'b0, 8'h77, 0, 0, 0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run(1'($urandom), 8'($urandom), int'($urandom_range(0, 16)),
                int'($urandom_range(0, 16)), int'($urandom_range(0, 5)), 1'($urandom));
        end

        // Asynchronous reset in the middle of ECC_RUN
        start = 1'b1; mode = 1'b1; seed_in = 8'h9E;
        for (int k = 1; k <= 7; k++) begin
            step();
            cur_k = k;
            start    = 1'b0;
            done_scr = (k == 4);
        end
        chk("pre_reset_en_ecc", en_ecc, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        prev_mux = 1'b0; prev_result = '0;
        chk_idle(8'h00);
        done_scr = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_idle(8'h00);
        end
        run(1'b1, 8'hC3, 2, 3, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
